trisc_ctrl_seq: RTL and testbench

Parametrised microsequencer for the TRISC processor: the next-generation control unit that drives the 16-bit datapath control word from a one-hot opcode. It generalises memory access to a configurable number of wait cycles and adds conditional jump (JZ), halt/resume (HLT) and illegal-opcode trapping. It sits between the instruction register (one-hot opcode, zero flag) and the datapath control lines C0..C15.

---
 rtl/trisc_ctrl_seq.sv | 125 ++++++++++++
 tb/tb_trisc_ctrl_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/trisc_ctrl_seq.sv
// TRISC microsequencer: one-hot opcode and zero flag in, 16-bit Moore control word out.
// Memory state groups last MEM_WAIT cycles; illegal opcodes trap to HALT.
module trisc_ctrl_seq #(
    parameter int unsigned OP_W     = 11,
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            run,
    output logic [15:0]     control,
    output logic            halted,
    output logic            illegal
);

    localparam int unsigned CTL_W = 16;
    localparam int unsigned WC_W  = 3;

    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_WAIT - 1);

    localparam logic [OP_W-1:0] OP_LDA = OP_W'(11'h400);
    localparam logic [OP_W-1:0] OP_STA = OP_W'(11'h200);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(11'h100);
    localparam logic [OP_W-1:0] OP_INC = OP_W'(11'h020);
    localparam logic [OP_W-1:0] OP_CLR = OP_W'(11'h010);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(11'h008);
    localparam logic [OP_W-1:0] OP_JZ  = OP_W'(11'h004);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(11'h002);

    typedef enum logic [4:0] {
        S_RST, S_F1, S_FW, S_DEC, S_INC, S_CLRA, S_LDW, S_LDX,
        S_STW, S_JMP, S_ADW, S_AD1, S_AD2, S_JZN, S_HALT, S_TRAP
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [WC_W-1:0]   r_wc, w_wc_nxt;
    logic              w_wait_done;
    logic [CTL_W-1:0]  r_control, w_ctl_nxt;
    logic              r_halted, r_illegal;

    function automatic logic [CTL_W-1:0] ctl_of(input state_t s);
        case (s)
            S_RST:   ctl_of = 16'h0001;
            S_F1:    ctl_of = 16'h0008;
            S_FW:    ctl_of = 16'h0018;
            S_DEC:   ctl_of = 16'h0084;
            S_INC:   ctl_of = 16'h0200;
            S_CLRA:  ctl_of = 16'h0100;
            S_LDW:   ctl_of = 16'h0010;
            S_LDX:   ctl_of = 16'h0800;
            S_STW:   ctl_of = 16'h0030;
            S_JMP:   ctl_of = 16'h000A;
            S_ADW:   ctl_of = 16'h0010;
            S_AD1:   ctl_of = 16'h4000;
            S_AD2:   ctl_of = 16'h0C00;
            S_JZN:   ctl_of = 16'h1000;
            default: ctl_of = 16'h0000;
        endcase
    endfunction

    // Next state, wait count and the control word of the next state
    always_comb begin
        w_state_nxt = S_RST;
        w_wc_nxt    = '0;
        w_wait_done = (r_wc == WC_LAST);
        case (r_state)
            S_RST:  w_state_nxt = S_F1;
            S_F1:   w_state_nxt = S_FW;
            S_FW, S_LDW, S_STW, S_ADW: begin
                if (!w_wait_done) begin
                    w_state_nxt = r_state;
                    w_wc_nxt    = r_wc + 3'd1;
                end else begin
                    case (r_state)
                        S_FW:    w_state_nxt = S_DEC;
                        S_LDW:   w_state_nxt = S_LDX;
                        S_ADW:   w_state_nxt = S_AD1;
                        default: w_state_nxt = S_F1;
                    endcase
                end
            end
            S_DEC: begin
                if      (op == OP_LDA) w_state_nxt = S_LDW;
                else if (op == OP_STA) w_state_nxt = S_STW;
                else if (op == OP_ADD) w_state_nxt = S_ADW;
                else if (op == OP_INC) w_state_nxt = S_INC;
                else if (op == OP_CLR) w_state_nxt = S_CLRA;
                else if (op == OP_JMP) w_state_nxt = S_JMP;
                else if (op == OP_JZ)  w_state_nxt = zero ? S_JMP : S_JZN;
                else if (op == OP_HLT) w_state_nxt = S_HALT;
                else                   w_state_nxt = S_TRAP;
            end
            S_INC, S_CLRA, S_LDX, S_AD2, S_JZN: w_state_nxt = S_F1;
            S_JMP:  w_state_nxt = S_FW;
            S_AD1:  w_state_nxt = S_AD2;
            S_HALT: w_state_nxt = run ? S_F1 : S_HALT;
            S_TRAP: w_state_nxt = S_HALT;
            default: w_state_nxt = S_RST;
        endcase
        w_ctl_nxt = ctl_of(w_state_nxt);
    end

    // Outputs are registered alongside the state so they never glitch on op/zero/run
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state   <= S_RST;
            r_wc      <= '0;
            r_control <= 16'h0001;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wc      <= w_wc_nxt;
            r_control <= w_ctl_nxt;
            r_halted  <= (w_state_nxt == S_HALT);
            r_illegal <= (w_state_nxt == S_TRAP);
        end
    end

    assign control = r_control;
    assign halted  = r_halted;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_trisc_ctrl_seq.sv
// Directed bench for trisc_ctrl_seq: W=2 instruction sequences, W=5 mid-instruction reset,
// and STA length at W=1 and W=7.
module tb_trisc_ctrl_seq;

    logic        CLK;
    logic [10:0] op;
    logic        zero, run;
    logic        clr2, clr5, clr1, clr7;
    logic [15:0] c2, c5, c1, c7;
    logic        h2, h5, h1, h7, il2, il5, il1, il7;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    trisc_ctrl_seq #(.OP_W(11), .MEM_WAIT(2)) u2 (.CLK(CLK), .CLR(clr2), .op(op), .zero(zero),
        .run(run), .control(c2), .halted(h2), .illegal(il2));
    trisc_ctrl_seq #(.OP_W(11), .MEM_WAIT(5)) u5 (.CLK(CLK), .CLR(clr5), .op(op), .zero(zero),
        .run(run), .control(c5), .halted(h5), .illegal(il5));
    trisc_ctrl_seq #(.OP_W(11), .MEM_WAIT(1)) u1 (.CLK(CLK), .CLR(clr1), .op(op), .zero(zero),
        .run(run), .control(c1), .halted(h1), .illegal(il1));
    trisc_ctrl_seq #(.OP_W(11), .MEM_WAIT(7)) u7 (.CLK(CLK), .CLR(clr7), .op(op), .zero(zero),
        .run(run), .control(c7), .halted(h7), .illegal(il7));

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ctl(input int sel);
        case (sel)
            1:       return c1;
            5:       return c5;
            7:       return c7;
            default: return c2;
        endcase
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic play(input string tag, input int sel);
        foreach (exp_q[i]) begin
            step();
            chk($sformatf("%s%0d", tag, i), ctl(sel), exp_q[i]);
        end
    endtask

    initial begin
        logic [10:0] bad_ops[3];
        int n1, n7, a1, b1, a7, b7;
        logic [2:0] mx1, mx7;
        bad_ops = '{11'h000, 11'h041, 11'h030};
        clr2 = 1'b0; clr5 = 1'b0; clr1 = 1'b0; clr7 = 1'b0;
        op = 11'h020; zero = 1'b0; run = 1'b0;
        #1;
        clr2 = 1'b1; clr5 = 1'b1; clr1 = 1'b1; clr7 = 1'b1;
        #1;
        chk("rst_ctl", c2, 16'h0001);
        chk("rst_flags", {14'b0, h2, il2}, 16'h0000);

        // INC from reset
        step();
        clr2 = 1'b0;
        exp_q = '{16'h0008, 16'h0018, 16'h0018, 16'h0084, 16'h0200, 16'h0008};
        play("inc", 2);

        op = 11'h400;
        exp_q = '{16'h0018, 16'h0018, 16'h0084, 16'h0010, 16'h0010, 16'h0800, 16'h0008};
        play("lda", 2);

        op = 11'h100;
        exp_q = '{16'h0018, 16'h0018, 16'h0084, 16'h0010, 16'h0010, 16'h4000, 16'h0C00, 16'h0008};
        play("add", 2);

        // JZ taken skips F1 on the target fetch; then not taken from the following DEC
        op = 11'h004; zero = 1'b1;
        exp_q = '{16'h0018, 16'h0018, 16'h0084, 16'h000A, 16'h0018, 16'h0018, 16'h0084};
        play("jz1_", 2);
        zero = 1'b0;
        exp_q = '{16'h1000, 16'h0008};
        play("jz0_", 2);

        for (int k = 0; k < 3; k++) begin
            op = bad_ops[k];
            exp_q = '{16'h0018, 16'h0018, 16'h0084};
            play($sformatf("ill%0d_", k), 2);
            step();
            chk($sformatf("trap%0d_ctl", k), c2, 16'h0000);
            chk($sformatf("trap%0d_flags", k), {14'b0, h2, il2}, 16'h0001);
            step();
            chk($sformatf("halt%0d_ctl", k), c2, 16'h0000);
            chk($sformatf("halt%0d_flags", k), {14'b0, h2, il2}, 16'h0002);
            for (int j = 0; j < (k == 0 ? 5 : 0); j++) begin
                step();
                chk($sformatf("hold%0d", j), {14'b0, h2, il2}, 16'h0002);
            end
            run = 1'b1;
            step();
            chk($sformatf("resume%0d", k), c2, 16'h0008);
            chk($sformatf("resume%0d_flags", k), {14'b0, h2, il2}, 16'h0000);
            run = 1'b0;
        end

        op = 11'h002;
        exp_q = '{16'h0018, 16'h0018, 16'h0084, 16'h0000};
        play("hlt", 2);
        chk("hlt_flags", {14'b0, h2, il2}, 16'h0002);
        run = 1'b1;
        step();
        chk("hlt_resume", c2, 16'h0008);
        run = 1'b0;

        // W=5: reset during the third LDW cycle
        op = 11'h400;
        clr5 = 1'b0;
        exp_q = '{16'h0008, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0084,
                  16'h0010, 16'h0010, 16'h0010};
        play("w5a_", 5);
        clr5 = 1'b1;
        #1;
        chk("w5_rst_ctl", c5, 16'h0001);
        chk("w5_rst_flags", {14'b0, h5, il5}, 16'h0000);
        chk("w5_rst_wc", 16'(u5.r_wc), 16'h0000);
        step();
        clr5 = 1'b0;
        exp_q = '{16'h0008, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h0084};
        play("w5b_", 5);

        // STA length at W=1 and W=7, measured F1 to F1
        op = 11'h200;
        clr1 = 1'b0; clr7 = 1'b0;
        n1 = 0; n7 = 0; a1 = 0; b1 = 0; a7 = 0; b7 = 0; mx1 = '0; mx7 = '0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (c1 == 16'h0008) begin
                if (n1 == 0) a1 = c; else if (n1 == 1) b1 = c;
                n1++;
            end
            if (c7 == 16'h0008) begin
                if (n7 == 0) a7 = c; else if (n7 == 1) b7 = c;
                n7++;
            end
            if (u1.r_wc > mx1) mx1 = u1.r_wc;
            if (u7.r_wc > mx7) mx7 = u7.r_wc;
        end
        chk("sta_len_w1", 16'((n1 >= 2) ? (b1 - a1) : 0), 16'd4);
        chk("sta_len_w7", 16'((n7 >= 2) ? (b7 - a7) : 0), 16'd16);
        chk("wc_max_w1", 16'(mx1), 16'd0);
        chk("wc_max_w7", 16'(mx7), 16'd6);
        chk("w1_flags", {14'b0, h1, il1}, 16'h0000);
        chk("w7_flags", {14'b0, h7, il7}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
